// File: rtl/pid_loop_sequencer_if.sv
// rtl/pid_loop_sequencer_if.sv - ADC, coefficient, PID core and PWM signal bundle of the servo loop sequencer
interface pid_loop_sequencer_if #(
   parameter int WIDTH = 12
);
   logic             enable_i;
   logic [WIDTH-1:0] ref_i;
   logic [WIDTH-1:0] adc_data_i;
   logic             adc_valid_i;
   logic             cfg_we_i;
   logic [1:0]       cfg_addr_i;
   logic [WIDTH-1:0] cfg_data_i;
   logic             status_clr_i;
   logic             pid_start_o;
   logic [WIDTH-1:0] pid_y_o;
   logic [WIDTH-1:0] pid_ref_o;
   logic [WIDTH-1:0] coeff_p_o;
   logic [WIDTH-1:0] coeff_i_o;
   logic [WIDTH-1:0] coeff_d_o;
   logic             pid_done_i;
   logic [WIDTH-1:0] pid_u_i;
   logic [WIDTH-1:0] pwm_duty_o;
   logic             pwm_load_o;
   logic             busy_o;
   logic             overrun_o;
   logic             timeout_o;

   modport slave (
      input  enable_i, ref_i, adc_data_i, adc_valid_i, cfg_we_i, cfg_addr_i, cfg_data_i,
             status_clr_i, pid_done_i, pid_u_i,
      output pid_start_o, pid_y_o, pid_ref_o, coeff_p_o, coeff_i_o, coeff_d_o,
             pwm_duty_o, pwm_load_o, busy_o, overrun_o, timeout_o
   );

   modport master (
      output enable_i, ref_i, adc_data_i, adc_valid_i, cfg_we_i, cfg_addr_i, cfg_data_i,
             status_clr_i, pid_done_i, pid_u_i,
      input  pid_start_o, pid_y_o, pid_ref_o, coeff_p_o, coeff_i_o, coeff_d_o,
             pwm_duty_o, pwm_load_o, busy_o, overrun_o, timeout_o
   );
endinterface

// File: rtl/pid_loop_sequencer.sv
// rtl/pid_loop_sequencer.sv - one ADC -> PID -> PWM servo iteration per sample period, with shadowed coefficients
module pid_loop_sequencer #(
   parameter int WIDTH      = 12,
   parameter int SAMPLE_DIV = 50000,
   parameter int TIMEOUT    = 1023,
   parameter int DUTY_MAX   = 4095,
   parameter int P_INIT     = 2,
   parameter int I_INIT     = 4,
   parameter int D_INIT     = 6
) (
   input logic                clk_i,
   input logic                reset,
   pid_loop_sequencer_if.slave bus
);
   localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_ADC = 3'd1,
      S_START    = 3'd2,
      S_COMPUTE  = 3'd3,
      S_UPDATE   = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    sample_cnt;
   logic [TW-1:0]    tmo_cnt;
   logic             tick, accept, overrun_set, timeout_set, tmo_hit;
   logic [WIDTH-1:0] ref_q, y_q, duty_q;
   logic [WIDTH-1:0] sh_p, sh_i, sh_d, act_p, act_i, act_d;
   logic             overrun_q, timeout_q;

   assign tick        = bus.enable_i && (sample_cnt == CW'(SAMPLE_DIV - 1));
   assign accept      = tick && (state == S_IDLE);
   assign overrun_set = tick && (state != S_IDLE);
   assign tmo_hit     = (tmo_cnt == TW'(TIMEOUT - 1));
   assign timeout_set = bus.enable_i && tmo_hit &&
                        (((state == S_WAIT_ADC) && !bus.adc_valid_i) ||
                         ((state == S_COMPUTE)  && !bus.pid_done_i));

   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset)
         sample_cnt <= '0;
      else if (!bus.enable_i || tick)
         sample_cnt <= '0;
      else
         sample_cnt <= sample_cnt + CW'(1);
   end

   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!bus.enable_i) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:     if (tick) state_nxt = S_WAIT_ADC;
            S_WAIT_ADC: if (bus.adc_valid_i) state_nxt = S_START;
                        else if (tmo_hit)    state_nxt = S_IDLE;
            S_START:    state_nxt = S_COMPUTE;
            S_COMPUTE:  if (bus.pid_done_i) state_nxt = S_UPDATE;
                        else if (tmo_hit)   state_nxt = S_IDLE;
            S_UPDATE:   state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.pid_start_o = 1'b0;
      bus.pwm_load_o  = 1'b0;
      bus.busy_o      = 1'b1;
      case (state)
         S_IDLE:   bus.busy_o      = 1'b0;
         S_START:  bus.pid_start_o = 1'b1;
         S_UPDATE: bus.pwm_load_o  = 1'b1;
         default:  ;
      endcase
   end

   // Handshake budget restarts on every state change, so it covers each waiting state separately.
   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset)
         tmo_cnt <= '0;
      else if (state_nxt != state)
         tmo_cnt <= '0;
      else if ((state == S_WAIT_ADC) || (state == S_COMPUTE))
         tmo_cnt <= tmo_cnt + TW'(1);
   end

   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         ref_q  <= '0;
         y_q    <= '0;
         duty_q <= '0;
      end else begin
         if (accept)
            ref_q <= bus.ref_i;
         if (bus.enable_i && (state == S_WAIT_ADC) && bus.adc_valid_i)
            y_q <= bus.adc_data_i;
         if (bus.enable_i && (state == S_COMPUTE) && bus.pid_done_i)
            duty_q <= (bus.pid_u_i > WIDTH'(DUTY_MAX)) ? WIDTH'(DUTY_MAX) : bus.pid_u_i;
      end
   end

   // Active set copies the shadow as it was before this edge, so a write on the accepting tick waits a period.
   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         sh_p  <= WIDTH'(P_INIT);
         sh_i  <= WIDTH'(I_INIT);
         sh_d  <= WIDTH'(D_INIT);
         act_p <= WIDTH'(P_INIT);
         act_i <= WIDTH'(I_INIT);
         act_d <= WIDTH'(D_INIT);
      end else begin
         if (bus.cfg_we_i) begin
            case (bus.cfg_addr_i)
               2'd0:    sh_p <= bus.cfg_data_i;
               2'd1:    sh_i <= bus.cfg_data_i;
               2'd2:    sh_d <= bus.cfg_data_i;
               default: ;
            endcase
         end
         if (accept) begin
            act_p <= sh_p;
            act_i <= sh_i;
            act_d <= sh_d;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         if (overrun_set)
            overrun_q <= 1'b1;
         else if (bus.status_clr_i)
            overrun_q <= 1'b0;
         if (timeout_set)
            timeout_q <= 1'b1;
         else if (bus.status_clr_i)
            timeout_q <= 1'b0;
      end
   end

   assign bus.pid_y_o    = y_q;
   assign bus.pid_ref_o  = ref_q;
   assign bus.pwm_duty_o = duty_q;
   assign bus.coeff_p_o  = act_p;
   assign bus.coeff_i_o  = act_i;
   assign bus.coeff_d_o  = act_d;
   assign bus.overrun_o  = overrun_q;
   assign bus.timeout_o  = timeout_q;

endmodule

// File: tb/tb_pid_loop_sequencer.sv
// tb/tb_pid_loop_sequencer.sv - scoreboard bench for pid_loop_sequencer
module tb_pid_loop_sequencer;
   localparam int W     = 12;
   localparam int DIV   = 8;
   localparam int TMO   = 15;
   localparam int DMAX  = 3000;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   last_rise = -1;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] last_duty = '0;

   pid_loop_sequencer_if #(.WIDTH(W)) bus ();

   pid_loop_sequencer #(
      .WIDTH(W), .SAMPLE_DIV(DIV), .TIMEOUT(TMO), .DUTY_MAX(DMAX),
      .P_INIT(2), .I_INIT(4), .D_INIT(6)
   ) dut (
      .clk_i (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (bus.pwm_load_o === 1'b1) begin
         if (exp_q.size() == 0)
            check_eq("unexpected_load", 32'(1), 32'(0));
         else
            check_eq("duty", 32'(bus.pwm_duty_o), 32'(exp_q.pop_front()));
      end
   end

   task automatic wait_rise(input bit chk_per, output bit ok);
      int n = 0;
      while (!bus.busy_o && n < 40) begin
         @(negedge clk);
         n++;
      end
      ok = bus.busy_o;
      if (!ok) begin
         check_eq("busy_rise_timeout", 32'(0), 32'(1));
      end else begin
         if (chk_per) check_eq("period", 32'(cyc - last_rise), 32'(DIV));
         last_rise = cyc;
      end
   endtask

   task automatic run_iter(input logic [W-1:0] adc, input logic [W-1:0] u,
                           input logic [W-1:0] rf, input bit do_cfg, input bit chk_per);
      bit ok;
      logic [W-1:0] expd;
      wait_rise(chk_per, ok);
      if (!ok) return;
      check_eq("pid_ref", 32'(bus.pid_ref_o), 32'(rf));
      bus.adc_data_i  = adc;
      bus.adc_valid_i = 1'b1;
      if (do_cfg) begin
         bus.cfg_we_i = 1'b1; bus.cfg_addr_i = 2'd0; bus.cfg_data_i = 12'd288;
      end
      @(negedge clk);
      bus.adc_valid_i = 1'b0;
      bus.cfg_we_i    = 1'b0;
      check_eq("start", 32'(bus.pid_start_o), 32'(1));
      check_eq("pid_y", 32'(bus.pid_y_o), 32'(adc));
      @(negedge clk);
      check_eq("start_one_cycle", 32'(bus.pid_start_o), 32'(0));
      expd = (u > 12'(DMAX)) ? 12'(DMAX) : u;
      exp_q.push_back(expd);
      last_duty = expd;
      bus.pid_u_i    = u;
      bus.pid_done_i = 1'b1;
      @(negedge clk);
      bus.pid_done_i = 1'b0;
      check_eq("load", 32'(bus.pwm_load_o), 32'(1));
      @(negedge clk);
      check_eq("load_one_cycle", 32'(bus.pwm_load_o), 32'(0));
      check_eq("idle_after", 32'(bus.busy_o), 32'(0));
   endtask

   initial begin
      bit ok;
      int n;
      rst_n = 1'b0;
      bus.enable_i = 1'b1; bus.ref_i = '0; bus.adc_data_i = '0; bus.adc_valid_i = 1'b0;
      bus.cfg_we_i = 1'b0; bus.cfg_addr_i = '0; bus.cfg_data_i = '0; bus.status_clr_i = 1'b0;
      bus.pid_done_i = 1'b0; bus.pid_u_i = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_busy", 32'(bus.busy_o), 32'(0));
      check_eq("rst_duty", 32'(bus.pwm_duty_o), 32'(0));
      check_eq("rst_y", 32'(bus.pid_y_o), 32'(0));
      check_eq("rst_ref", 32'(bus.pid_ref_o), 32'(0));
      check_eq("rst_p", 32'(bus.coeff_p_o), 32'(2));
      check_eq("rst_i", 32'(bus.coeff_i_o), 32'(4));
      check_eq("rst_d", 32'(bus.coeff_d_o), 32'(6));
      check_eq("rst_flags", 32'({bus.overrun_o, bus.timeout_o}), 32'(0));
      check_eq("rst_strobes", 32'({bus.pid_start_o, bus.pwm_load_o}), 32'(0));
      rst_n = 1'b1;
      bus.ref_i = 12'd100;

      run_iter(12'd11, 12'd300, 12'd100, 1'b0, 1'b0);
      run_iter(12'd22, 12'd4095, 12'd100, 1'b0, 1'b1);
      bus.ref_i = 12'd200;
      run_iter(12'd33, 12'd3000, 12'd200, 1'b0, 1'b1);
      run_iter(12'd44, 12'd3001, 12'd200, 1'b0, 1'b1);
      run_iter(12'd55, 12'd0, 12'd200, 1'b0, 1'b1);

      run_iter(12'd66, 12'd123, 12'd200, 1'b1, 1'b1);
      check_eq("p_shadowed", 32'(bus.coeff_p_o), 32'(2));
      bus.cfg_we_i = 1'b1; bus.cfg_addr_i = 2'd1; bus.cfg_data_i = 12'd100;
      @(negedge clk);
      bus.cfg_addr_i = 2'd3; bus.cfg_data_i = 12'd777;
      @(negedge clk);
      bus.cfg_we_i = 1'b0;
      run_iter(12'd77, 12'd500, 12'd200, 1'b0, 1'b0);
      check_eq("p_applied", 32'(bus.coeff_p_o), 32'(288));
      check_eq("i_applied", 32'(bus.coeff_i_o), 32'(100));
      check_eq("d_kept", 32'(bus.coeff_d_o), 32'(6));

      wait_rise(1'b1, ok);
      n = 0;
      while (bus.busy_o && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_eq("timeout_len", 32'(n), 32'(TMO));
      check_eq("timeout_flag", 32'(bus.timeout_o), 32'(1));
      check_eq("timeout_overrun", 32'(bus.overrun_o), 32'(1));
      check_eq("timeout_duty_held", 32'(bus.pwm_duty_o), 32'(last_duty));
      bus.enable_i = 1'b0;
      @(negedge clk);
      bus.status_clr_i = 1'b1;
      @(negedge clk);
      bus.status_clr_i = 1'b0;
      bus.enable_i = 1'b1;
      check_eq("flags_cleared", 32'({bus.overrun_o, bus.timeout_o}), 32'(0));

      wait_rise(1'b0, ok);
      bus.adc_data_i = 12'd88; bus.adc_valid_i = 1'b1;
      @(negedge clk);
      bus.adc_valid_i = 1'b0;
      repeat (6) @(negedge clk);
      bus.status_clr_i = 1'b1;
      @(negedge clk);
      bus.status_clr_i = 1'b0;
      check_eq("overrun_set_wins", 32'(bus.overrun_o), 32'(1));
      check_eq("overrun_busy", 32'(bus.busy_o), 32'(1));
      check_eq("overrun_no_timeout", 32'(bus.timeout_o), 32'(0));
      exp_q.push_back(12'd1000);
      last_duty = 12'd1000;
      bus.pid_u_i = 12'd1000; bus.pid_done_i = 1'b1;
      @(negedge clk);
      bus.pid_done_i = 1'b0;
      check_eq("overrun_load", 32'(bus.pwm_load_o), 32'(1));
      @(negedge clk);
      bus.status_clr_i = 1'b1;
      @(negedge clk);
      bus.status_clr_i = 1'b0;
      check_eq("overrun_cleared", 32'(bus.overrun_o), 32'(0));

      wait_rise(1'b0, ok);
      bus.adc_data_i = 12'd99; bus.adc_valid_i = 1'b1;
      @(negedge clk);
      bus.adc_valid_i = 1'b0;
      @(negedge clk);
      bus.enable_i = 1'b0;
      @(negedge clk);
      check_eq("en_drop_idle", 32'(bus.busy_o), 32'(0));
      check_eq("en_drop_no_load", 32'(bus.pwm_load_o), 32'(0));
      check_eq("en_drop_duty", 32'(bus.pwm_duty_o), 32'(last_duty));
      check_eq("en_drop_p_held", 32'(bus.coeff_p_o), 32'(288));
      bus.enable_i = 1'b1;

      wait_rise(1'b0, ok);
      bus.adc_data_i = 12'd5; bus.adc_valid_i = 1'b1;
      @(negedge clk);
      bus.adc_valid_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("rst_mid_idle", 32'(bus.busy_o), 32'(0));
      check_eq("rst_mid_duty", 32'(bus.pwm_duty_o), 32'(0));
      check_eq("rst_mid_y", 32'(bus.pid_y_o), 32'(0));
      check_eq("rst_mid_p", 32'(bus.coeff_p_o), 32'(2));
      check_eq("rst_mid_i", 32'(bus.coeff_i_o), 32'(4));
      @(negedge clk);
      rst_n = 1'b1;
      run_iter(12'd101, 12'd700, 12'd200, 1'b0, 1'b0);
      check_eq("p_after_reset", 32'(bus.coeff_p_o), 32'(2));
      repeat (2) @(negedge clk);
      check_eq("scoreboard_empty", 32'(exp_q.size()), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=running expected=finished");
      $fatal(1, "watchdog");
   end
endmodule
